// File: rtl/addr_gen_wb_pkg.sv
// Shared types for the LSTM write-back address generator and its sibling generators.
// State encodings are fixed so the read-side generators can decode them consistently.
package addr_gen_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

    // The stall counter runs from PAUSE_LEN-1 down to 0, giving PAUSE_LEN stalled cycles.
    function automatic int pause_load_val(input int pause_len);
        return (pause_len > 0) ? pause_len - 1 : 0;
    endfunction

endpackage

// File: rtl/addr_gen_wb_if.sv
// Result-stream input and RAM write-port output of the write-back address generator.
interface addr_gen_wb_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_ready;
    logic                  o_we;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_data;

    modport master (
        output i_valid, i_data,
        input  o_ready, o_we, o_addr, o_data
    );

    modport slave (
        input  i_valid, i_data,
        output o_ready, o_we, o_addr, o_data
    );
endinterface

// File: rtl/addr_gen_wb_stall_counter.sv
// Down-counter timing the stall inserted after each row; expired_o is high at zero.
module stall_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/addr_gen_wb.sv
// Write-side address generator: stamps accepted result words with sequential RAM
// addresses, stalls after every row, and flags done once STOP has been written.
module addr_gen_wb
    import addr_gen_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int BASE       = 0,
    parameter int STOP       = 56,
    parameter int ROW_LEN    = 53,
    parameter int PAUSE_LEN  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    addr_gen_wb_if.slave bus,
    output logic         o_done
);
    localparam logic [ADDR_WIDTH-1:0] BASE_A     = ADDR_WIDTH'(BASE);
    localparam logic [ADDR_WIDTH-1:0] STOP_A     = ADDR_WIDTH'(STOP);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST   = ADDR_WIDTH'(ROW_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] PAUSE_LOAD = ADDR_WIDTH'(pause_load_val(PAUSE_LEN));
    localparam bit                    HAS_PAUSE  = (PAUSE_LEN > 0);

    if (STOP < BASE) begin : g_bad_range
        $error("addr_gen_wb: STOP must not be below BASE");
    end
    if (ROW_LEN < 1) begin : g_bad_row
        $error("addr_gen_wb: ROW_LEN must be at least 1");
    end

    wb_state_e             state_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  done_q;

    logic accept;
    logic at_stop;
    logic row_end;
    logic pause_load;
    logic pause_dec;
    logic pause_expired;

    assign bus.o_ready = (state_q == ST_WRITE) && en;
    assign accept      = bus.i_valid && bus.o_ready;
    assign at_stop     = (wr_ptr_q == STOP_A);
    assign row_end     = (row_cnt_q == ROW_LAST);
    assign wr_ptr_d    = wr_ptr_q + 1'b1;
    assign row_cnt_d   = row_end ? '0 : row_cnt_q + 1'b1;

    // The last word of the frame takes precedence over the end-of-row stall.
    assign pause_load  = accept && !at_stop && row_end && HAS_PAUSE;
    assign pause_dec   = (state_q == ST_PAUSE) && en;

    stall_counter #(
        .W (ADDR_WIDTH)
    ) u_stall (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pause_load),
        .load_val_i (PAUSE_LOAD),
        .dec_i      (pause_dec),
        .expired_o  (pause_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= BASE_A;
            row_cnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= BASE_A;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q <= wr_ptr_q;
                data_q <= bus.i_data;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (en) state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (accept) begin
                        if (at_stop) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            wr_ptr_q  <= wr_ptr_d;
                            row_cnt_q <= row_cnt_d;
                            if (row_end && HAS_PAUSE) state_q <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (en && pause_expired) state_q <= ST_WRITE;
                end
                ST_DONE: begin
                    // Dropping en after a finished frame rearms the generator at BASE.
                    if (!en) begin
                        state_q   <= ST_IDLE;
                        wr_ptr_q  <= BASE_A;
                        row_cnt_q <= '0;
                        done_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.o_we   = we_q;
    assign bus.o_addr = addr_q;
    assign bus.o_data = data_q;
    assign o_done     = done_q;
endmodule

// File: tb/tb_addr_gen_wb.sv
// Directed bench for addr_gen_wb: default geometry plus two edge-parameter instances.
module tb_addr_gen_wb;

    logic clk;
    logic rst;
    logic en_r;
    logic valid_r;
    logic [15:0] data_r;
    int sel;
    int n_chk;
    int n_pass;

    logic en0, en1, en2;
    logic done0, done1, done2;

    addr_gen_wb_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus0 ();
    addr_gen_wb_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus1 ();
    addr_gen_wb_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus2 ();

    addr_gen_wb u0 (.clk(clk), .rst(rst), .en(en0), .bus(bus0.slave), .o_done(done0));
    addr_gen_wb #(.ROW_LEN(4), .PAUSE_LEN(0), .STOP(7)) u1 (
        .clk(clk), .rst(rst), .en(en1), .bus(bus1.slave), .o_done(done1));
    addr_gen_wb #(.ROW_LEN(4), .PAUSE_LEN(2), .STOP(3)) u2 (
        .clk(clk), .rst(rst), .en(en2), .bus(bus2.slave), .o_done(done2));

    assign en0 = en_r && (sel == 0);
    assign en1 = en_r && (sel == 1);
    assign en2 = en_r && (sel == 2);
    assign bus0.i_valid = valid_r && (sel == 0);
    assign bus1.i_valid = valid_r && (sel == 1);
    assign bus2.i_valid = valid_r && (sel == 2);
    assign bus0.i_data = data_r;
    assign bus1.i_data = data_r;
    assign bus2.i_data = data_r;

    logic s_ready, s_we, s_done;
    logic [11:0] s_addr;
    logic [15:0] s_data;

    always_comb begin
        s_ready = bus0.o_ready;
        s_we    = bus0.o_we;
        s_done  = done0;
        s_addr  = bus0.o_addr;
        s_data  = bus0.o_data;
        if (sel == 1) begin
            s_ready = bus1.o_ready;
            s_we    = bus1.o_we;
            s_done  = done1;
            s_addr  = bus1.o_addr;
            s_data  = bus1.o_data;
        end else if (sel == 2) begin
            s_ready = bus2.o_ready;
            s_we    = bus2.o_we;
            s_done  = done2;
            s_addr  = bus2.o_addr;
            s_data  = bus2.o_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        en_r = 1'b0;
        valid_r = 1'b0;
        data_r = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rst_we"},   32'(s_we),   32'h0);
        chk({tag, "_rst_addr"}, 32'(s_addr), 32'h0);
        chk({tag, "_rst_data"}, 32'(s_data), 32'h0);
        chk({tag, "_rst_done"}, 32'(s_done), 32'h0);
        chk({tag, "_rst_rdy"},  32'(s_ready), 32'h0);
        rst = 1'b0;
    endtask

    // Streams a whole frame with i_valid held high; i_data = A000 + n on the n-th accept.
    // Stall length after address k is PAUSE_LEN when k closes a row, else 0.
    task automatic run_frame(input string tag, input int stop, input int row_len, input int pause_len);
        int nacc;
        int gap;
        int exp_gap;
        logic acc;
        nacc = 0;
        gap = 0;
        en_r = 1'b1;
        valid_r = 1'b1;
        data_r = 16'hA000;
        for (int c = 0; c < 400 && nacc <= stop; c++) begin
            @(negedge clk);
            acc = s_ready && valid_r;
            if (!acc && nacc > 0) gap++;
            @(posedge clk);
            #1;
            chk({tag, "_we"}, 32'(s_we), 32'(acc));
            if (acc) begin
                if (nacc > 0) begin
                    exp_gap = (pause_len > 0 && (nacc % row_len) == 0) ? pause_len : 0;
                    chk($sformatf("%s_gap%0d", tag, nacc - 1), 32'(gap), 32'(exp_gap));
                end
                chk($sformatf("%s_addr%0d", tag, nacc), 32'(s_addr), 32'(nacc));
                chk($sformatf("%s_data%0d", tag, nacc), 32'(s_data), 32'(32'hA000 + nacc));
                nacc++;
                gap = 0;
                data_r = 16'(32'hA000 + nacc);
            end
            chk({tag, "_done"}, 32'(s_done), 32'(nacc == stop + 1));
        end
        chk({tag, "_count"}, 32'(nacc), 32'(stop + 1));
        valid_r = 1'b0;
        @(negedge clk);
        chk({tag, "_post_rdy"}, 32'(s_ready), 32'h0);
        @(posedge clk);
        #1;
        chk({tag, "_post_we"},   32'(s_we),   32'h0);
        chk({tag, "_post_done"}, 32'(s_done), 32'h1);
    endtask

    bit en_t[12]  = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    bit val_t[12] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit we_t[12]  = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    int addr_t[12] = '{0, 0, 0, 1, 2, 2, 2, 2, 2, 2, 3, 3};

    initial begin
        int pend;
        bit found;
        n_chk = 0;
        n_pass = 0;
        sel = 0;
        rst = 1'b1;
        en_r = 1'b0;
        valid_r = 1'b0;
        data_r = 16'h0;

        // Default geometry: rows of 53, 2-cycle stall, frame ends at 56.
        do_reset("t1");
        run_frame("t1", 56, 53, 2);

        // Restart after done: en low clears done, next frame starts at 0 again.
        en_r = 1'b0;
        @(posedge clk);
        #1;
        chk("t7_done_clr", 32'(s_done), 32'h0);
        run_frame("t7", 56, 53, 2);

        // Backpressure and an en gap mid-row.
        do_reset("t3");
        en_r = 1'b1;
        @(posedge clk);
        #1;
        pend = 0;
        for (int i = 0; i < 12; i++) begin
            en_r = en_t[i];
            valid_r = val_t[i];
            data_r = val_t[i] ? 16'(32'hA000 + pend) : 16'hBEEF;
            @(negedge clk);
            chk($sformatf("t3_rdy%0d", i), 32'(s_ready), 32'(en_t[i]));
            @(posedge clk);
            #1;
            chk($sformatf("t3_we%0d", i),   32'(s_we),   32'(we_t[i]));
            chk($sformatf("t3_addr%0d", i), 32'(s_addr), 32'(addr_t[i]));
            chk($sformatf("t3_data%0d", i), 32'(s_data), 32'(32'hA000 + addr_t[i]));
            if (we_t[i]) pend++;
        end
        valid_r = 1'b0;

        // Reset one cycle after the accept of address 20.
        do_reset("t6");
        en_r = 1'b1;
        valid_r = 1'b1;
        data_r = 16'hA000;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk);
            #1;
            if (s_we) data_r = 16'(32'hA000 + 32'(s_addr) + 1);
            if (s_we && s_addr == 12'd20) found = 1'b1;
        end
        chk("t6_reach20", 32'(found), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_we_killed", 32'(s_we),   32'h0);
        chk("t6_addr_rst",  32'(s_addr), 32'h0);
        chk("t6_data_rst",  32'(s_data), 32'h0);
        chk("t6_done_rst",  32'(s_done), 32'h0);
        rst = 1'b0;
        en_r = 1'b0;
        valid_r = 1'b0;
        run_frame("t6", 56, 53, 2);

        // ROW_LEN=4, PAUSE_LEN=0, STOP=7: eight writes with no stall.
        sel = 1;
        do_reset("t4");
        run_frame("t4", 7, 4, 0);

        // ROW_LEN=4, PAUSE_LEN=2, STOP=3: done on the row end with no stall.
        sel = 2;
        do_reset("t5");
        run_frame("t5", 3, 4, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
